// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Runtime-configurable divided-clock generator and sequencer for the NIOS_II
// peripheral clock domain. It produces a 50%-duty clock from clk_1m with a
// programmable half period. A run is either continuous (burst length 0) or
// lasts a fixed number of output periods.
//
// Every change to the output takes effect on a period boundary, which is the
// rising edge of clk_out. This covers new configurations, stop requests, and
// the end of a burst. As a result, clk_out never shows a runt pulse.
// Asynchronous reset is the one exception: it forces clk_out high at once.
//
// Ports
//   clk_1m     in   1        system clock (1 MHz)
//   rst_n      in   1        asynchronous reset, active low
//   cfg_wr     in   1        strobe: capture cfg_half / cfg_burst into shadow
//   cfg_half   in   CNT_W    half period minus 1
//   cfg_burst  in   BURST_W  periods per run, 0 = continuous
//   start      in   1        pulse: begin a run (IDLE only)
//   stop       in   1        pulse: end the run at the next boundary (RUN only)
//   clk_out    out  1        divided clock, idles high
//   tick       out  1        pulse per completed period (clk_out 0->1)
//   busy       out  1        high while running
//   cfg_ack    out  1        pulse when shadow is copied into active registers
//   done       out  1        pulse when a run ends
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DEF_HALF = 49,
   parameter int unsigned BURST_W  = 8
) (
   input  logic               clk_1m,
   input  logic               rst_n,
   input  logic               cfg_wr,
   input  logic [CNT_W-1:0]   cfg_half,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               start,
   input  logic               stop,
   output logic               clk_out,
   output logic               tick,
   output logic               busy,
   output logic               cfg_ack,
   output logic               done
);

   localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [BURST_W-1:0] per_cnt_q,   per_cnt_d;
   logic [CNT_W-1:0]   half_sh_q,   half_sh_d;
   logic [BURST_W-1:0] burst_sh_q,  burst_sh_d;
   logic [CNT_W-1:0]   half_act_q,  half_act_d;
   logic [BURST_W-1:0] burst_act_q, burst_act_d;
   logic               stop_pend_q, stop_pend_d;
   logic               cfg_pend_q,  cfg_pend_d;
   logic               clk_out_q,   clk_out_d;
   logic               tick_q,      tick_d;
   logic               busy_q,      busy_d;
   logic               cfg_ack_q,   cfg_ack_d;
   logic               done_q,      done_d;

   // The period count after the current boundary. It wraps naturally at
   // 2^BURST_W. The wrap only matters in continuous mode.
   logic [BURST_W-1:0] per_cnt_inc;
   logic               half_hit;
   logic               boundary;
   logic               burst_end;

   assign per_cnt_inc = per_cnt_q + BURST_W'(1);
   assign half_hit    = (cnt_q == half_act_q);
   // The boundary is the half-period expiry that drives clk_out from low to high.
   assign boundary    = half_hit && !clk_out_q;
   // This uses the burst length that was active before any same-cycle reconfig.
   assign burst_end   = (burst_act_q != '0) && (per_cnt_inc == burst_act_q);

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      per_cnt_d   = per_cnt_q;
      half_sh_d   = half_sh_q;
      burst_sh_d  = burst_sh_q;
      half_act_d  = half_act_q;
      burst_act_d = burst_act_q;
      stop_pend_d = stop_pend_q;
      cfg_pend_d  = cfg_pend_q;
      clk_out_d   = clk_out_q;
      tick_d      = 1'b0;
      cfg_ack_d   = 1'b0;
      done_d      = 1'b0;

      // The shadow always tracks the latest write, whatever the state.
      // The *_sh_d values below are therefore the freshest configuration.
      // A cfg_wr in this cycle overrides an older pending shadow.
      if (cfg_wr) begin
         half_sh_d  = cfg_half;
         burst_sh_d = cfg_burst;
         cfg_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            clk_out_d   = 1'b1;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
            // Nothing is toggling, so a new configuration is applied at once.
            // When start arrives in the same cycle, the run uses these values.
            if (cfg_wr || cfg_pend_q) begin
               half_act_d  = half_sh_d;
               burst_act_d = burst_sh_d;
               cfg_ack_d   = 1'b1;
               cfg_pend_d  = 1'b0;
            end
            if (start) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               per_cnt_d = '0;
            end
         end

         ST_RUN: begin
            if (half_hit) begin
               cnt_d     = '0;
               clk_out_d = ~clk_out_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end

            if (boundary) begin
               tick_d    = 1'b1;
               per_cnt_d = per_cnt_inc;
               if (cfg_wr || cfg_pend_q) begin
                  half_act_d  = half_sh_d;
                  burst_act_d = burst_sh_d;
                  cfg_ack_d   = 1'b1;
                  cfg_pend_d  = 1'b0;
               end
               // Leaving on the rising edge means clk_out is already at its idle
               // level, so the last period is always complete.
               if (stop_pend_q || stop || burst_end) begin
                  state_d     = ST_IDLE;
                  done_d      = 1'b1;
                  stop_pend_d = 1'b0;
               end
            end else if (stop) begin
               // A stop request is held until the period completes.
               stop_pend_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         per_cnt_q   <= '0;
         half_sh_q   <= DEF_HALF_V;
         burst_sh_q  <= '0;
         half_act_q  <= DEF_HALF_V;
         burst_act_q <= '0;
         stop_pend_q <= 1'b0;
         cfg_pend_q  <= 1'b0;
         clk_out_q   <= 1'b1;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ack_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         per_cnt_q   <= per_cnt_d;
         half_sh_q   <= half_sh_d;
         burst_sh_q  <= burst_sh_d;
         half_act_q  <= half_act_d;
         burst_act_q <= burst_act_d;
         stop_pend_q <= stop_pend_d;
         cfg_pend_q  <= cfg_pend_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         busy_q      <= busy_d;
         cfg_ack_q   <= cfg_ack_d;
         done_q      <= done_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign busy    = busy_q;
   assign cfg_ack = cfg_ack_q;
   assign done    = done_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Testbench for clk_div_ctrl. Each scenario queues the output events it
// expects, in order, with their hand-computed cycle numbers. The events are
// clk_out edges, tick, cfg_ack, done, and busy edges. A monitor on the falling
// clock edge turns each observed event into a pop-and-compare against that
// queue.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int EV_FALL = 0;
   localparam int EV_RISE = 1;
   localparam int EV_TICK = 2;
   localparam int EV_ACK  = 3;
   localparam int EV_DONE = 4;
   localparam int EV_UP   = 5;
   localparam int EV_DN   = 6;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;

   logic        clk_1m = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_wr = 1'b0;
   logic [15:0] cfg_half = '0;
   logic [7:0]  cfg_burst = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clk_out, tick, busy, cfg_ack, done;
   logic        prev_clk = 1'b1;
   logic        prev_busy = 1'b0;

   clk_div_ctrl #(.CNT_W(16), .DEF_HALF(49), .BURST_W(8)) dut (
      .clk_1m   (clk_1m),
      .rst_n    (rst_n),
      .cfg_wr   (cfg_wr),
      .cfg_half (cfg_half),
      .cfg_burst(cfg_burst),
      .start    (start),
      .stop     (stop),
      .clk_out  (clk_out),
      .tick     (tick),
      .busy     (busy),
      .cfg_ack  (cfg_ack),
      .done     (done)
   );

   always #5 clk_1m = ~clk_1m;

   // The cycle number is the count of rising edges seen so far.
   always @(posedge clk_1m) cyc <= cyc + 1;

   function automatic string kname(int k);
      case (k)
         EV_FALL: return "clk_out_fall";
         EV_RISE: return "clk_out_rise";
         EV_TICK: return "tick";
         EV_ACK:  return "cfg_ack";
         EV_DONE: return "done";
         EV_UP:   return "busy_rise";
         EV_DN:   return "busy_fall";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(int k, int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(int k);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(k), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event_seq: got %s at cycle %0d, required %s at cycle %0d",
                     kname(k), cyc, kname(e.kind), e.cyc);
         end
      end
   endtask

   // Monitor: the fixed order of checks here sets the order of events that
   // share a cycle.
   always @(negedge clk_1m) begin
      if (clk_out !== prev_clk) observe(clk_out ? EV_RISE : EV_FALL);
      if (tick === 1'b1)        observe(EV_TICK);
      if (cfg_ack === 1'b1)     observe(EV_ACK);
      if (done === 1'b1)        observe(EV_DONE);
      if (busy !== prev_busy)   observe(busy ? EV_UP : EV_DN);
      prev_clk  = clk_out;
      prev_busy = busy;
   end

   task automatic check(string name, logic act, logic req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk_1m);
      #1;
   endtask

   task automatic goto(int t);
      while (cyc < t) step();
   endtask

   // Each pulse is driven so that the DUT samples it at rising edge t.
   task automatic pulse_start(int t);
      goto(t - 1);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop(int t);
      goto(t - 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic pulse_cfg(int t, int h, int b);
      goto(t - 1);
      cfg_half  = 16'(h);
      cfg_burst = 8'(b);
      cfg_wr    = 1'b1;
      step();
      cfg_wr    = 1'b0;
   endtask

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, b, b2;

      #1 rst_n = 1'b0;
      step(); step(); step();
      check("rst_clk_out", clk_out, 1'b1);
      check("rst_busy",    busy,    1'b0);
      check("rst_tick",    tick,    1'b0);
      check("rst_cfg_ack", cfg_ack, 1'b0);
      check("rst_done",    done,    1'b0);
      rst_n = 1'b1;
      step();

      // 1: defaults, period 100, then stop during the high phase of period 4.
      b = cyc + 2;
      push(EV_UP, b);
      for (int k = 1; k <= 4; k++) begin
         push(EV_FALL, b + 100*k - 50);
         push(EV_RISE, b + 100*k);
         push(EV_TICK, b + 100*k);
      end
      push(EV_DONE, b + 400);
      push(EV_DN,   b + 400);
      pulse_start(b);
      pulse_stop(b + 310);
      drain("s1", 200);

      // 2: cfg in IDLE (half 4, burst 3), three 10-cycle periods.
      s = cyc + 2;
      b = s + 5;
      push(EV_ACK, s);
      push(EV_UP, b);
      for (int k = 1; k <= 3; k++) begin
         push(EV_FALL, b + 10*k - 5);
         push(EV_RISE, b + 10*k);
         push(EV_TICK, b + 10*k);
      end
      push(EV_DONE, b + 30);
      push(EV_DN,   b + 30);
      pulse_cfg(s, 4, 3);
      pulse_start(b);
      drain("s2", 60);

      // 3: continuous half 9, reconfig to half 2 in the low phase of period 2.
      s = cyc + 2;
      b = s + 3;
      push(EV_ACK, s);
      push(EV_UP, b);
      push(EV_FALL, b + 10);
      push(EV_RISE, b + 20); push(EV_TICK, b + 20);
      push(EV_FALL, b + 30);
      push(EV_RISE, b + 40); push(EV_TICK, b + 40); push(EV_ACK, b + 40);
      push(EV_FALL, b + 43);
      push(EV_RISE, b + 46); push(EV_TICK, b + 46);
      push(EV_FALL, b + 49);
      push(EV_RISE, b + 52); push(EV_TICK, b + 52);
      push(EV_FALL, b + 55);
      push(EV_RISE, b + 58); push(EV_TICK, b + 58);
      push(EV_DONE, b + 58); push(EV_DN, b + 58);
      pulse_cfg(s, 9, 0);
      pulse_start(b);
      pulse_cfg(b + 35, 2, 0);
      pulse_stop(b + 53);
      drain("s3", 60);

      // 4: stop mid-period, stop ignored in IDLE, relaunch, start ignored in RUN.
      s  = cyc + 2;
      b  = s + 2;
      b2 = b + 22;
      push(EV_ACK, s);
      push(EV_UP, b);
      push(EV_FALL, b + 10);
      push(EV_RISE, b + 20); push(EV_TICK, b + 20);
      push(EV_DONE, b + 20); push(EV_DN, b + 20);
      push(EV_UP, b2);
      push(EV_FALL, b2 + 10);
      push(EV_RISE, b2 + 20); push(EV_TICK, b2 + 20);
      push(EV_FALL, b2 + 30);
      push(EV_RISE, b2 + 40); push(EV_TICK, b2 + 40);
      push(EV_DONE, b2 + 40); push(EV_DN, b2 + 40);
      pulse_cfg(s, 9, 0);
      pulse_start(b);
      pulse_stop(b + 13);
      pulse_stop(b + 21);
      pulse_start(b2);
      pulse_start(b2 + 5);
      pulse_stop(b2 + 25);
      drain("s4", 60);

      // 5: half 0, burst 4, cfg and start together, stop on the final boundary.
      b = cyc + 2;
      push(EV_ACK, b);
      push(EV_UP, b);
      for (int k = 1; k <= 4; k++) begin
         push(EV_FALL, b + 2*k - 1);
         push(EV_RISE, b + 2*k);
         push(EV_TICK, b + 2*k);
      end
      push(EV_DONE, b + 8);
      push(EV_DN,   b + 8);
      goto(b - 1);
      cfg_half  = 16'd0;
      cfg_burst = 8'd4;
      cfg_wr    = 1'b1;
      start     = 1'b1;
      step();
      cfg_wr    = 1'b0;
      start     = 1'b0;
      pulse_stop(b + 8);
      drain("s5", 30);

      // 6: asynchronous reset in the low phase, then the default period returns.
      s = cyc + 2;
      b = s + 2;
      push(EV_ACK, s);
      push(EV_UP, b);
      push(EV_FALL, b + 10);
      push(EV_RISE, b + 14);
      push(EV_DN,   b + 14);
      pulse_cfg(s, 9, 0);
      pulse_start(b);
      goto(b + 14);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_clk_out", clk_out, 1'b1);
      check("async_rst_busy",    busy,    1'b0);
      step(); step();
      rst_n = 1'b1;
      drain("s6a", 10);

      b = cyc + 2;
      push(EV_UP, b);
      push(EV_FALL, b + 50);
      push(EV_RISE, b + 100); push(EV_TICK, b + 100);
      push(EV_FALL, b + 150);
      push(EV_RISE, b + 200); push(EV_TICK, b + 200);
      push(EV_DONE, b + 200); push(EV_DN, b + 200);
      pulse_start(b);
      pulse_stop(b + 120);
      drain("s6b", 120);

      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
